hazard_fwd_ctrl: RTL and testbench

- Central hazard and forwarding controller for the 5-stage RISC-V pipeline.
- Keeps shadow copies of the destination-register metadata for the EX, MEM and WB stages.
- Drives the 2-bit select of the two EX-stage 3:1 operand muxes (A and B).
- Generates load-use stalls and branch flushes for the IF/ID and ID/EX pipeline registers.

---
 rtl/hazard_fwd_ctrl_pkg.sv | 37 +++
 rtl/hazard_fwd_ctrl_fwd_sel.sv | 39 +++
 rtl/hazard_fwd_ctrl.sv | 101 ++++++++++
 tb/tb_hazard_fwd_ctrl.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/hazard_fwd_ctrl_pkg.sv
// Shared definitions for the hazard/forwarding controller.
// Holds the operand-mux select encodings, register-index width and the
// shadow records kept for the EX, MEM and WB stages.
package hazard_fwd_ctrl_pkg;

  localparam int REG_AW = 5;
  localparam int SEL_W  = 2;

  // Operand-mux select encodings (2'b11 is never driven)
  localparam logic [SEL_W-1:0] FWD_REG = 2'b00;
  localparam logic [SEL_W-1:0] FWD_WB  = 2'b01;
  localparam logic [SEL_W-1:0] FWD_MEM = 2'b10;

  localparam logic [REG_AW-1:0] REG_X0 = 5'd0;

  // Full record for the instruction currently in EX
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
    logic              mem_read;
  } ex_rec_t;

  // Reduced record for MEM and WB: only the write-back destination matters
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
  } wb_rec_t;

  localparam ex_rec_t EX_BUBBLE = '{valid: 1'b0, rs1: 5'd0, rs2: 5'd0,
                                    rd: 5'd0, reg_write: 1'b0, mem_read: 1'b0};
  localparam wb_rec_t WB_EMPTY  = '{valid: 1'b0, rd: 5'd0, reg_write: 1'b0};

endpackage

// File: rtl/hazard_fwd_ctrl_fwd_sel.sv
// fwd_sel_unit: combinational forwarding priority compare for one EX operand.
// Ports:
//   ex_valid - EX stage holds a real instruction
//   src      - EX source register index for this operand
//   mem_rec  - MEM stage destination record
//   wb_rec   - WB stage destination record
//   sel      - mux select: FWD_MEM beats FWD_WB beats FWD_REG
module fwd_sel_unit
  import hazard_fwd_ctrl_pkg::*;
(
  input  logic              ex_valid,
  input  logic [REG_AW-1:0] src,
  input  wb_rec_t           mem_rec,
  input  wb_rec_t           wb_rec,
  output logic [SEL_W-1:0]  sel
);

  logic mem_hit;
  logic wb_hit;

  // x0 is hard-wired zero, so a producer targeting it is never a hit
  assign mem_hit = mem_rec.valid & mem_rec.reg_write & (mem_rec.rd != REG_X0) & (mem_rec.rd == src);
  assign wb_hit  = wb_rec.valid  & wb_rec.reg_write  & (wb_rec.rd  != REG_X0) & (wb_rec.rd  == src);

  // Priority select: the younger MEM result wins over the older WB result
  always_comb begin
    sel = FWD_REG;
    if (!ex_valid) begin
      sel = FWD_REG;
    end else if (mem_hit) begin
      sel = FWD_MEM;
    end else if (wb_hit) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_REG;
    end
  end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// hazard_fwd_ctrl: hazard and forwarding controller for the 5-stage pipeline.
// Tracks destination metadata for EX/MEM/WB, drives the EX operand mux
// selects, and raises load-use stalls and branch flushes.
// Ports:
//   clk, rst          - rising-edge clock, synchronous active-high reset
//   ext_stall         - global freeze; all shadow records hold
//   id_*              - decoded fields of the instruction currently in ID
//   ex_branch_taken   - branch/jump resolved taken in EX
//   fwd_a, fwd_b      - operand A/B mux selects (00 reg, 01 WB, 10 MEM)
//   stall_if_id       - hold PC and IF/ID
//   bubble_ex         - load a NOP into ID/EX
//   flush_if_id       - clear IF/ID
// All outputs are combinational from the shadow records and current ID inputs.
module hazard_fwd_ctrl
  import hazard_fwd_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              ext_stall,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              ex_branch_taken,
  output logic [SEL_W-1:0]  fwd_a,
  output logic [SEL_W-1:0]  fwd_b,
  output logic              stall_if_id,
  output logic              bubble_ex,
  output logic              flush_if_id
);

  ex_rec_t ex_rec;
  wb_rec_t mem_rec;
  wb_rec_t wb_rec;
  ex_rec_t ex_next;
  wb_rec_t ex_as_wb;
  logic    load_use;

  fwd_sel_unit u_fwd_a (
    .ex_valid (ex_rec.valid),
    .src      (ex_rec.rs1),
    .mem_rec  (mem_rec),
    .wb_rec   (wb_rec),
    .sel      (fwd_a)
  );

  fwd_sel_unit u_fwd_b (
    .ex_valid (ex_rec.valid),
    .src      (ex_rec.rs2),
    .mem_rec  (mem_rec),
    .wb_rec   (wb_rec),
    .sel      (fwd_b)
  );

  // A load in EX whose data the ID instruction needs cannot be forwarded in time
  assign load_use = ex_rec.valid & ex_rec.mem_read & (ex_rec.rd != REG_X0) & id_valid &
                    ((ex_rec.rd == id_rs1) | (ex_rec.rd == id_rs2));

  // A taken branch squashes both younger instructions, so it overrides the stall
  assign flush_if_id = ex_branch_taken;
  assign bubble_ex   = ex_branch_taken | load_use;
  assign stall_if_id = load_use & ~ex_branch_taken;

  // The branch itself still advances into MEM; only ID/EX gets the bubble
  assign ex_as_wb = '{valid: ex_rec.valid, rd: ex_rec.rd, reg_write: ex_rec.reg_write};

  // Next EX record: bubble on stall/flush, otherwise the ID instruction
  always_comb begin
    ex_next = EX_BUBBLE;
    if (bubble_ex) begin
      ex_next = EX_BUBBLE;
    end else begin
      ex_next.valid     = id_valid;
      ex_next.rs1       = id_rs1;
      ex_next.rs2       = id_rs2;
      ex_next.rd        = id_rd;
      ex_next.reg_write = id_reg_write;
      ex_next.mem_read  = id_mem_read;
    end
  end

  // Shadow record pipeline: reset clears, freeze holds, otherwise advance
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_rec  <= EX_BUBBLE;
      mem_rec <= WB_EMPTY;
      wb_rec  <= WB_EMPTY;
    end else if (!ext_stall) begin
      ex_rec  <= ex_next;
      mem_rec <= ex_as_wb;
      wb_rec  <= mem_rec;
    end else begin
      ex_rec  <= ex_rec;
      mem_rec <= mem_rec;
      wb_rec  <= wb_rec;
    end
  end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
module tb_hazard_fwd_ctrl;

  logic       clk;
  logic       rst;
  logic       ext_stall;
  logic       id_valid;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic [4:0] id_rd;
  logic       id_reg_write;
  logic       id_mem_read;
  logic       ex_branch_taken;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;
  logic       stall_if_id;
  logic       bubble_ex;
  logic       flush_if_id;

  int checks;
  int errors;

  hazard_fwd_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .ext_stall       (ext_stall),
    .id_valid        (id_valid),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_rd           (id_rd),
    .id_reg_write    (id_reg_write),
    .id_mem_read     (id_mem_read),
    .ex_branch_taken (ex_branch_taken),
    .fwd_a           (fwd_a),
    .fwd_b           (fwd_b),
    .stall_if_id     (stall_if_id),
    .bubble_ex       (bubble_ex),
    .flush_if_id     (flush_if_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       es;
    logic       iv;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
    logic       br;
    logic [1:0] ea;
    logic [1:0] eb;
    logic       est;
    logic       ebu;
    logic       efl;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic r, input logic es, input logic iv,
                             input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                             input logic rw, input logic mr, input logic br,
                             input logic [1:0] ea, input logic [1:0] eb,
                             input logic est, input logic ebu, input logic efl);
    vec_t t;
    t.rst = r; t.es = es; t.iv = iv; t.rs1 = rs1; t.rs2 = rs2; t.rd = rd;
    t.rw = rw; t.mr = mr; t.br = br; t.ea = ea; t.eb = eb;
    t.est = est; t.ebu = ebu; t.efl = efl;
    return t;
  endfunction

  // Drive one cycle's inputs at the falling edge, check just after, then let the rising edge pass
  task automatic apply(input vec_t t, input string name);
    @(negedge clk);
    rst = t.rst; ext_stall = t.es; id_valid = t.iv;
    id_rs1 = t.rs1; id_rs2 = t.rs2; id_rd = t.rd;
    id_reg_write = t.rw; id_mem_read = t.mr; ex_branch_taken = t.br;
    #1;
    checks++;
    if (fwd_a !== t.ea || fwd_b !== t.eb || stall_if_id !== t.est ||
        bubble_ex !== t.ebu || flush_if_id !== t.efl) begin
      errors++;
      $display("FAIL %s: got a=%b b=%b stall=%b bubble=%b flush=%b, expected a=%b b=%b stall=%b bubble=%b flush=%b",
               name, fwd_a, fwd_b, stall_if_id, bubble_ex, flush_if_id,
               t.ea, t.eb, t.est, t.ebu, t.efl);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1; ext_stall = 1'b0; id_valid = 1'b0;
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_rd = 5'd0;
    id_reg_write = 1'b0; id_mem_read = 1'b0; ex_branch_taken = 1'b0;
    @(posedge clk);

    //            rst es iv rs1 rs2 rd  rw mr br  a  b  st bu fl
    tbl.push_back(v(1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0)); // reset cycle 2
    tbl.push_back(v(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0)); // idle after reset
    tbl.push_back(v(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 1, 1, 2, 5,  1, 0, 0, 0, 0, 0, 0, 0)); // add x5
    tbl.push_back(v(0, 0, 1, 5, 5, 6,  1, 0, 0, 0, 0, 0, 0, 0)); // sub x6,x5,x5
    tbl.push_back(v(0, 0, 0, 0, 0, 0,  0, 0, 0, 2, 2, 0, 0, 0)); // sub in EX: both from MEM
    tbl.push_back(v(0, 0, 1, 0, 0, 8,  1, 0, 0, 0, 0, 0, 0, 0)); // add x8
    tbl.push_back(v(0, 0, 1, 1, 2, 9,  1, 0, 0, 0, 0, 0, 0, 0)); // unrelated
    tbl.push_back(v(0, 0, 1, 8, 3, 10, 1, 0, 0, 0, 0, 0, 0, 0)); // consumer of x8
    tbl.push_back(v(0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0, 0)); // fwd_a from WB
    tbl.push_back(v(0, 0, 1, 0, 0, 7,  1, 0, 0, 0, 0, 0, 0, 0)); // x7 producer 1
    tbl.push_back(v(0, 0, 1, 0, 0, 7,  1, 0, 0, 0, 0, 0, 0, 0)); // x7 producer 2
    tbl.push_back(v(0, 0, 1, 1, 7, 11, 1, 0, 0, 0, 0, 0, 0, 0)); // consumer rs2=x7
    tbl.push_back(v(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 2, 0, 0, 0)); // MEM wins over WB
    tbl.push_back(v(0, 0, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0)); // write x0
    tbl.push_back(v(0, 0, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0)); // write x0
    tbl.push_back(v(0, 0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0)); // reads x0, MEM rd=x0
    tbl.push_back(v(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0)); // x0 never forwarded
    tbl.push_back(v(0, 0, 1, 1, 0, 3,  1, 1, 0, 0, 0, 0, 0, 0)); // lw x3
    tbl.push_back(v(0, 0, 1, 4, 3, 12, 1, 0, 0, 0, 0, 1, 1, 0)); // load-use stall
    tbl.push_back(v(0, 0, 1, 4, 3, 12, 1, 0, 0, 0, 0, 0, 0, 0)); // bubble in EX, no stall
    tbl.push_back(v(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 0, 0)); // consumer gets WB load
    tbl.push_back(v(0, 0, 1, 1, 0, 3,  1, 1, 0, 0, 0, 0, 0, 0)); // lw x3
    tbl.push_back(v(0, 0, 1, 3, 0, 14, 1, 0, 1, 0, 0, 0, 1, 1)); // load-use + branch: flush wins
    tbl.push_back(v(0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0, 1, 1)); // branch alone
    tbl.push_back(v(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 1, 1, 0, 0,  1, 1, 0, 0, 0, 0, 0, 0)); // lw x0
    tbl.push_back(v(0, 0, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0)); // lw x0 + reader of x0: no stall
    tbl.push_back(v(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0)); // MEM rd=x0 not forwarded

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], $sformatf("vec%0d", i));
    end

    // Freeze during a load-use hazard: records hold, exactly one bubble after release
    apply(v(0, 0, 1, 1, 0, 3,  1, 1, 0, 0, 0, 0, 0, 0), "frz_lw");
    apply(v(0, 1, 1, 3, 5, 13, 1, 0, 0, 0, 0, 1, 1, 0), "frz_1");
    apply(v(0, 1, 1, 3, 5, 13, 1, 0, 0, 0, 0, 1, 1, 0), "frz_2");
    apply(v(0, 1, 1, 3, 5, 13, 1, 0, 0, 0, 0, 1, 1, 0), "frz_3");
    apply(v(0, 0, 1, 3, 5, 13, 1, 0, 0, 0, 0, 1, 1, 0), "frz_release");
    apply(v(0, 0, 1, 3, 5, 13, 1, 0, 0, 0, 0, 0, 0, 0), "frz_single_bubble");
    apply(v(0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0, 0), "frz_fwd_wb");

    // Reset in the middle of a frozen stall discards it
    apply(v(0, 0, 1, 1, 0, 3,  1, 1, 0, 0, 0, 0, 0, 0), "rst_lw");
    apply(v(0, 1, 1, 0, 3, 15, 1, 0, 0, 0, 0, 1, 1, 0), "rst_stall");
    apply(v(1, 1, 1, 0, 3, 15, 1, 0, 0, 0, 0, 1, 1, 0), "rst_assert");
    apply(v(0, 1, 1, 0, 3, 15, 1, 0, 0, 0, 0, 0, 0, 0), "rst_clean");
    apply(v(0, 0, 1, 0, 3, 15, 1, 0, 0, 0, 0, 0, 0, 0), "rst_clean2");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
